sobel_window_generator: RTL and testbench
=========================================

Name: sobel_window_generator

Overview:
- Producer side of the Sobel gradient datapath: accepts a raster-order 8-bit grayscale pixel stream and emits 3x3 neighbourhoods on P0..P8 with a start_calculations strobe.
- Drives the horizontal/vertical gradient blocks directly.
- Uses two internal line buffers and a 3-column shift window.
- Emits interior windows only; no border padding.

Parameters:
- IMG_WIDTH, 64, pixels per row (>=3).
- IMG_HEIGHT, 64, rows per frame (>=3).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sof  input  1  start of frame; qualifies the pixel presented in the same cycle as pixel (0,0).
- pixel_valid  input  1  pixel_in accepted this cycle.
- pixel_in  input  8  grayscale pixel, raster order.
- P0..P8  output  8 each  window pixels. P0/P1/P2 are top row left to right, P3/P4/P5 middle, P6/P7/P8 bottom; P8 is the newest pixel.
- start_calculations  output  1  one-cycle pulse; P0..P8 hold a complete window.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, rst=1):
  - P0..P8=0, start_calculations=0, frame_done=0.
  - col=0, row=0.
  - Line buffer contents are don't-care, but no window may be flagged until rows 0..2 are refilled.
- Accept: a pixel is accepted when pixel_valid=1. No backpressure; gaps in pixel_valid are allowed and freeze all state (pulses deassert).
- Counters:
  - col counts 0..IMG_WIDTH-1; at wrap it returns to 0 and row increments.
  - row counts 0..IMG_HEIGHT-1; at wrap it returns to 0.
  - Counter widths are $clog2 of the respective parameter.
- sof handling: sof=1 with pixel_valid=1 forces the accepted pixel to be treated as (0,0) regardless of counter state. Subsequent pixels continue from (0,1). sof with pixel_valid=0 is ignored.
- Datapath on accept at (r,c):
  - top_rd=lb_top[c] (row r-2); mid_rd=lb_mid[c] (row r-1).
  - Line buffer writes: lb_top[c]<=mid_rd, lb_mid[c]<=pixel_in.
  - Window shift: P0<=P1, P1<=P2, P2<=top_rd; P3<=P4, P4<=P5, P5<=mid_rd; P6<=P7, P7<=P8, P8<=pixel_in.
- Window valid: start_calculations=1 in the cycle after accepting (r,c) with r>=2 and c>=2. The window centre is then (r-1,c-1).
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes per frame.
- Between strobes, P0..P8 may change (columns 0,1 of each row). Consumers sample only on start_calculations.
- Latency: one clock from accepting the pixel to the strobe.
- frame_done=1 in the cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1). It coincides with the final start_calculations pulse.
- Mid-frame reset or sof: no window may be flagged until row>=2 of the new frame. Stale line buffer data is never flagged as valid.
- Pixel values pass through unmodified; no arithmetic on data.

Optional Feature:
- Macro: WINDOW_COORD_EN.
- When defined, adds two outputs:
  - center_row, $clog2(IMG_HEIGHT) bits.
  - center_col, $clog2(IMG_WIDTH) bits.
- Both are registered alongside start_calculations and equal (r-1,c-1) of the current window. Reset value is 0; they hold between strobes.
- When not defined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, pixel(r,c)=16r+c unless noted):
- Full frame with sof on first pixel and pixel_valid held high:
  - First strobe occurs one cycle after accepting (2,2), with P0..P8 = 0,1,2,16,17,18,32,33,34.
  - Exactly 4 strobes in total.
  - Last strobe has P0..P8 = 17,18,19,33,34,35,49,50,51 and coincides with frame_done.
- Same frame with pixel_valid toggling 1/0 every cycle: identical windows in the same order; each strobe lasts one cycle; outputs hold during gaps.
- Two back-to-back frames, second frame using pixel=255-(16r+c): no strobe during second-frame rows 0–1; first window of frame 2 is 255,254,253,239,238,237,223,222,221.
- sof asserted at (2,1) of frame 1: no strobe until new row 2, col 2; 4 windows follow, all from new-frame data.
- rst asserted asynchronously mid-row 3: all outputs are 0 within the same cycle; after release plus a sof frame, normal windows resume with no spurious strobe.
- With WINDOW_COORD_EN defined, full frame: (center_row,center_col) sequence is (1,1),(1,2),(2,1),(2,2).

Source files
------------

// File: rtl/sobel_window_if.sv
// ============================================================================
// Module   : sobel_window_if
// Purpose  : Pixel-stream input and 3x3 window output bundle for the Sobel
//            window generator. WINDOW_COORD_EN adds the window-centre outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sobel_window_if #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
);
    logic       sof;
    logic       pixel_valid;
    logic [7:0] pixel_in;

    logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
    logic       start_calculations;
    logic       frame_done;

`ifdef WINDOW_COORD_EN
    logic [$clog2(IMG_HEIGHT)-1:0] center_row;
    logic [$clog2(IMG_WIDTH)-1:0]  center_col;

    modport slave (
        input  sof, pixel_valid, pixel_in,
        output P0, P1, P2, P3, P4, P5, P6, P7, P8,
        output start_calculations, frame_done,
        output center_row, center_col
    );

    modport master (
        output sof, pixel_valid, pixel_in,
        input  P0, P1, P2, P3, P4, P5, P6, P7, P8,
        input  start_calculations, frame_done,
        input  center_row, center_col
    );
`else
    modport slave (
        input  sof, pixel_valid, pixel_in,
        output P0, P1, P2, P3, P4, P5, P6, P7, P8,
        output start_calculations, frame_done
    );

    modport master (
        output sof, pixel_valid, pixel_in,
        input  P0, P1, P2, P3, P4, P5, P6, P7, P8,
        input  start_calculations, frame_done
    );
`endif

endinterface

`default_nettype wire

// File: rtl/sobel_window_generator.sv
// ============================================================================
// Module   : sobel_window_generator
// Purpose  : Turns a raster 8-bit pixel stream into 3x3 interior windows using
//            two line buffers and a 3-column shift window. Optional macro
//            WINDOW_COORD_EN adds registered window-centre coordinates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_window_generator #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sobel_window_if.slave     bus
);

    localparam int c_COL_W = $clog2(IMG_WIDTH);
    localparam int c_ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_MIN_COL  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_MIN_ROW  = c_ROW_W'(2);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;

    logic [c_COL_W-1:0] w_col_eff;
    logic [c_ROW_W-1:0] w_row_eff;
    logic [c_COL_W-1:0] w_col_nxt;
    logic [c_ROW_W-1:0] w_row_nxt;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_win_ok;
    logic               w_accept;

    logic [7:0] r_lb_top [IMG_WIDTH];
    logic [7:0] r_lb_mid [IMG_WIDTH];
    logic [7:0] w_top_rd;
    logic [7:0] w_mid_rd;

    logic [7:0] r_win [9];
    logic       r_start;
    logic       r_done;

    assign w_accept = bus.pixel_valid;

    // sof re-anchors the accepted pixel at (0,0); the row gate below then
    // keeps stale line-buffer contents from ever being flagged.
    always_comb begin
        w_col_eff  = bus.sof ? '0 : r_col;
        w_row_eff  = bus.sof ? '0 : r_row;
        w_col_last = (w_col_eff == c_LAST_COL);
        w_row_last = (w_row_eff == c_LAST_ROW);
        w_col_nxt  = w_col_last ? '0 : w_col_eff + 1'b1;
        w_row_nxt  = w_row_eff;
        if (w_col_last) begin
            w_row_nxt = w_row_last ? '0 : w_row_eff + 1'b1;
        end
        w_win_ok   = (w_row_eff >= c_MIN_ROW) && (w_col_eff >= c_MIN_COL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    assign w_top_rd = r_lb_top[w_col_eff];
    assign w_mid_rd = r_lb_mid[w_col_eff];

    // Line buffers carry no reset: their contents are never trusted until
    // two fresh rows have been written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb_top[w_col_eff] <= w_mid_rd;
            r_lb_mid[w_col_eff] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= w_accept && w_win_ok;
            r_done  <= w_accept && w_row_last && w_col_last;
            if (w_accept) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_top_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_mid_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= bus.pixel_in;
            end
        end
    end

`ifdef WINDOW_COORD_EN
    logic [c_ROW_W-1:0] r_center_row;
    logic [c_COL_W-1:0] r_center_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_center_row <= '0;
            r_center_col <= '0;
        end else if (w_accept && w_win_ok) begin
            r_center_row <= w_row_eff - 1'b1;
            r_center_col <= w_col_eff - 1'b1;
        end
    end

    assign bus.center_row = r_center_row;
    assign bus.center_col = r_center_col;
`endif

    assign bus.P0 = r_win[0];
    assign bus.P1 = r_win[1];
    assign bus.P2 = r_win[2];
    assign bus.P3 = r_win[3];
    assign bus.P4 = r_win[4];
    assign bus.P5 = r_win[5];
    assign bus.P6 = r_win[6];
    assign bus.P7 = r_win[7];
    assign bus.P8 = r_win[8];

    assign bus.start_calculations = r_start;
    assign bus.frame_done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_generator.sv
// ============================================================================
// Module   : tb_sobel_window_generator
// Purpose  : Scoreboard bench for sobel_window_generator on a 4x4 image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_window_generator;

    localparam int c_W = 4;
    localparam int c_H = 4;

    typedef struct {
        logic [71:0] win;
        logic        fd;
        int          acc;
        logic [3:0]  coord;
    } exp_t;

    // Hand-computed windows {P0..P8} for pixel(r,c)=16r+c and 255-(16r+c)
    logic [71:0] c_WIN_A [4] = '{
        {8'd0,  8'd1,  8'd2,  8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34},
        {8'd1,  8'd2,  8'd3,  8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35},
        {8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34, 8'd48, 8'd49, 8'd50},
        {8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35, 8'd49, 8'd50, 8'd51}
    };
    logic [71:0] c_WIN_B [4] = '{
        {8'd255, 8'd254, 8'd253, 8'd239, 8'd238, 8'd237, 8'd223, 8'd222, 8'd221},
        {8'd254, 8'd253, 8'd252, 8'd238, 8'd237, 8'd236, 8'd222, 8'd221, 8'd220},
        {8'd239, 8'd238, 8'd237, 8'd223, 8'd222, 8'd221, 8'd207, 8'd206, 8'd205},
        {8'd238, 8'd237, 8'd236, 8'd222, 8'd221, 8'd220, 8'd206, 8'd205, 8'd204}
    };
    // 1-based raster index of the pixel that completes each window: (2,2),(2,3),(3,2),(3,3)
    int          c_ACC_OFF [4] = '{11, 12, 15, 16};
    logic [3:0]  c_COORD   [4] = '{4'b0101, 4'b0110, 4'b1001, 4'b1010};

    logic clk = 1'b0;
    logic rst = 1'b1;

    sobel_window_if #(.IMG_WIDTH(c_W), .IMG_HEIGHT(c_H)) dut_if ();

    sobel_window_generator #(.IMG_WIDTH(c_W), .IMG_HEIGHT(c_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          n_acc    = 0;
    exp_t        sb [$];
    logic        hold_chk = 1'b0;
    logic        prev_pv  = 1'b0;
    logic [71:0] prev_w   = '0;
    exp_t        m_e;

    function automatic logic [71:0] cur_win();
        return {dut_if.P0, dut_if.P1, dut_if.P2, dut_if.P3, dut_if.P4,
                dut_if.P5, dut_if.P6, dut_if.P7, dut_if.P8};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (dut_if.pixel_valid === 1'b1) n_acc++;
    end

    // Monitor: pops one expected window per strobe
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_if.start_calculations) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 72'd1, 72'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("window", cur_win(), m_e.win);
                    chk("frame_done_at_strobe", {71'd0, dut_if.frame_done}, {71'd0, m_e.fd});
                    chk("strobe_latency", 72'(n_acc), 72'(m_e.acc));
`ifdef WINDOW_COORD_EN
                    chk("center_coord", {68'd0, dut_if.center_row, dut_if.center_col},
                        {68'd0, m_e.coord});
`endif
                end
            end else begin
                chk("frame_done_idle", {71'd0, dut_if.frame_done}, 72'd0);
            end
            if (hold_chk && !prev_pv) begin
                chk("gap_hold_window", cur_win(), prev_w);
                chk("gap_no_strobe", {71'd0, dut_if.start_calculations}, 72'd0);
            end
            prev_w  = cur_win();
            prev_pv = dut_if.pixel_valid;
        end
    end

    task automatic push_frame(input logic inv, input int base, input int cnt);
        exp_t e;
        for (int k = 0; k < cnt; k++) begin
            e.win   = inv ? c_WIN_B[k] : c_WIN_A[k];
            e.fd    = (k == 3);
            e.acc   = base + c_ACC_OFF[k];
            e.coord = c_COORD[k];
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        dut_if.sof         = 1'b0;
        dut_if.pixel_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic s, input logic [7:0] v);
        dut_if.sof         = s;
        dut_if.pixel_valid = 1'b1;
        dut_if.pixel_in    = v;
        @(posedge clk);
        #1;
        dut_if.sof         = 1'b0;
        dut_if.pixel_valid = 1'b0;
    endtask

    task automatic send_frame(input logic inv, input logic toggle, input int npix);
        logic [7:0] v;
        for (int k = 0; k < npix; k++) begin
            v = 8'((k / c_W) * 16 + (k % c_W));
            if (inv) v = 8'd255 - v;
            send_px(k == 0, v);
            if (toggle) idle(1);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_window"}, cur_win(), 72'd0);
        chk({name, "_strobe"}, {71'd0, dut_if.start_calculations}, 72'd0);
        chk({name, "_frame_done"}, {71'd0, dut_if.frame_done}, 72'd0);
`ifdef WINDOW_COORD_EN
        chk({name, "_coord"}, {68'd0, dut_if.center_row, dut_if.center_col}, 72'd0);
`endif
    endtask

    initial begin
        dut_if.sof         = 1'b0;
        dut_if.pixel_valid = 1'b0;
        dut_if.pixel_in    = 8'd0;
        #10;
        chk_reset_outputs("reset");
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Full frame, continuous valid
        push_frame(1'b0, n_acc, 4);
        send_frame(1'b0, 1'b0, 16);
        idle(3);
        chk("t1_all_windows_seen", 72'(sb.size()), 72'd0);

        // Same frame with valid toggling every cycle
        hold_chk = 1'b1;
        push_frame(1'b0, n_acc, 4);
        send_frame(1'b0, 1'b1, 16);
        idle(3);
        hold_chk = 1'b0;
        chk("t2_all_windows_seen", 72'(sb.size()), 72'd0);

        // Back-to-back frames, second one inverted
        push_frame(1'b0, n_acc, 4);
        push_frame(1'b1, n_acc + 16, 4);
        send_frame(1'b0, 1'b0, 16);
        send_frame(1'b1, 1'b0, 16);
        idle(3);
        chk("t3_all_windows_seen", 72'(sb.size()), 72'd0);

        // sof lands on (2,1) of a partial frame
        send_frame(1'b0, 1'b0, 9);
        push_frame(1'b1, n_acc, 4);
        send_frame(1'b1, 1'b0, 16);
        idle(3);
        chk("t4_all_windows_seen", 72'(sb.size()), 72'd0);

        // Async reset during the (3,2) strobe; that strobe is never observed
        push_frame(1'b0, n_acc, 2);
        send_frame(1'b0, 1'b0, 15);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("midrow_reset");
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        chk("t5_pre_reset_windows_seen", 72'(sb.size()), 72'd0);
        push_frame(1'b0, n_acc, 4);
        send_frame(1'b0, 1'b0, 16);
        idle(3);
        chk("t5_post_reset_windows_seen", 72'(sb.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
